dilithium_in_packer: RTL and testbench



---
 rtl/dilithium_in_packer_pkg.sv | 17 +
 rtl/dilithium_in_packer_if.sv | 48 ++++
 rtl/dilithium_in_packer_stream_fifo.sv | 65 ++++++
 rtl/dilithium_in_packer.sv | 126 ++++++++++++
 tb/tb_dilithium_in_packer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dilithium_in_packer_pkg.sv
// Shared types and widths for the dilithium input packer.
package dilithium_pkg;

  localparam int DATA_W = 64;  // packed beat width toward the core
  localparam int HOST_W = 32;  // host/DMA word width
  localparam int MODE_W = 2;
  localparam int SEC_W  = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    FILL_LO = 3'd2,
    FILL_HI = 3'd3,
    DRAIN   = 3'd4
  } packer_state_t;

endpackage

// File: rtl/dilithium_in_packer_if.sv
// Host command/word bus plus the core-facing stream of the input packer.
// slave  = the packer's view, master = the host/core environment's view.
interface dilithium_in_packer_if #(
  parameter int CNT_W = 16
);

  logic                                cmd_valid;
  logic                                cmd_ready;
  logic [dilithium_pkg::MODE_W-1:0]    cmd_mode;
  logic [dilithium_pkg::SEC_W-1:0]     cmd_sec_lvl;

  logic                                s_valid;
  logic                                s_ready;
  logic [dilithium_pkg::HOST_W-1:0]    s_data;
  logic                                s_last;

  logic                                start;
  logic [dilithium_pkg::MODE_W-1:0]    mode;
  logic [dilithium_pkg::SEC_W-1:0]     sec_lvl;

  logic                                out_valid;
  logic                                out_ready;
  logic [dilithium_pkg::DATA_W-1:0]    out_data;

  logic [CNT_W-1:0]                    beat_cnt;
  logic                                busy;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_sec_lvl,
    input  s_valid, s_data, s_last,
    input  out_ready,
    output cmd_ready, s_ready,
    output start, mode, sec_lvl,
    output out_valid, out_data,
    output beat_cnt, busy
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_sec_lvl,
    output s_valid, s_data, s_last,
    output out_ready,
    input  cmd_ready, s_ready,
    input  start, mode, sec_lvl,
    input  out_valid, out_data,
    input  beat_cnt, busy
  );

endinterface

// File: rtl/dilithium_in_packer_stream_fifo.sv
// Small synchronous FIFO with a registered head (no fall-through from the
// write port) and full/empty flags. Storage is cleared on reset so the head
// reads zero after a flush.
module stream_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_fire;
  logic             pop_fire;

  // A push into a full FIFO or a pop from an empty one is dropped.
  assign push_fire = push_i && (count_q != DEPTH_C);
  assign pop_fire  = pop_i && (count_q != '0);

  // Storage, pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_fire) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;

endmodule

// File: rtl/dilithium_in_packer.sv
// Feeds the dilithium core: latches a command, pulses start, packs host word
// pairs little-endian into 64-bit beats (odd tail zero-padded) and queues the
// beats in a small FIFO. A new command is only taken once the previous
// message has fully drained to the core.
module dilithium_in_packer
  import dilithium_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dilithium_in_packer_if.slave   bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  packer_state_t       state_q;
  logic                start_q;
  logic [MODE_W-1:0]   mode_q;
  logic [SEC_W-1:0]    sec_lvl_q;
  logic [HOST_W-1:0]   lo_q;
  logic [CNT_W-1:0]    beat_cnt_q;

  logic                in_fill;
  logic                s_ready_w;
  logic                accept;
  logic                push;
  logic [DATA_W-1:0]   push_data;
  logic                pop;
  logic                drain_done;

  logic [DATA_W-1:0]   fifo_data;
  logic                fifo_valid;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;

  assign in_fill   = (state_q == FILL_LO) || (state_q == FILL_HI);
  assign s_ready_w = in_fill && !fifo_full && !rst;
  assign accept    = bus.s_valid && s_ready_w;

  // A beat is complete on the high word, or on a last word landing in the low half.
  assign push      = accept && ((state_q == FILL_HI) || bus.s_last);
  assign push_data = (state_q == FILL_HI) ? {bus.s_data, lo_q}
                                          : {{HOST_W{1'b0}}, bus.s_data};
  assign pop       = fifo_valid && bus.out_ready;

  // Leave DRAIN in the same cycle the last queued beat is taken by the core.
  assign drain_done = fifo_empty || ((fifo_count == CW'(1)) && pop);

  stream_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .data_o      (fifo_data),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Message FSM with command latch, low-half holding register and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      mode_q     <= '0;
      sec_lvl_q  <= '0;
      lo_q       <= '0;
      beat_cnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      if (push && (beat_cnt_q != {CNT_W{1'b1}})) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            mode_q     <= bus.cmd_mode;
            sec_lvl_q  <= bus.cmd_sec_lvl;
            beat_cnt_q <= '0;
            start_q    <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          state_q <= FILL_LO;
        end
        FILL_LO: begin
          if (accept) begin
            lo_q    <= bus.s_data;
            state_q <= bus.s_last ? DRAIN : FILL_HI;
          end
        end
        FILL_HI: begin
          if (accept) begin
            state_q <= bus.s_last ? DRAIN : FILL_LO;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign bus.s_ready   = s_ready_w;
  assign bus.start     = start_q;
  assign bus.mode      = mode_q;
  assign bus.sec_lvl   = sec_lvl_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_data;
  assign bus.beat_cnt  = beat_cnt_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dilithium_in_packer.sv
// Directed bench for dilithium_in_packer: table of messages plus hand-written
// back-pressure, busy-command and mid-message reset sequences.
module tb_dilithium_in_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dilithium_in_packer_if #(.CNT_W(16)) bus ();

  dilithium_in_packer #(
    .FIFO_DEPTH (2),
    .CNT_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_start = 0;
  int last_pop_cyc = 0;
  logic [63:0] rx_q [$];

  typedef struct {
    logic [1:0]        mode;
    logic [2:0]        sec;
    int                nw;
    logic [3:0][31:0]  w;
    int                nb;
    logic [1:0][63:0]  b;
    logic [15:0]       cnt;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_sec_lvl", bus.sec_lvl, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_beat_cnt", bus.beat_cnt, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  // Offer a command, wait for acceptance; returns in the cycle after the handshake.
  task automatic send_cmd(input logic [1:0] m, input logic [2:0] s);
    int k;
    k = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_mode    = m;
    bus.cmd_sec_lvl = s;
    while (!bus.cmd_ready && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("cmd_ready_timeout", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Present one host word and hold it until accepted; s_valid stays high.
  task automatic send_word(input logic [31:0] d, input logic last, output int stalls);
    int k;
    k = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("s_ready_timeout", bus.s_ready, 1);
    stalls = k;
    tick();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!bus.cmd_ready && k < 200) begin
      tick();
      k++;
    end
    chk("idle_reached", bus.cmd_ready, 1);
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core-side monitor: collects popped beats, counts start pulses and checks
  // that a presented beat is held until taken.
  initial begin
    logic        prev_v;
    logic        prev_pop;
    logic [63:0] prev_d;
    prev_v = 1'b0;
    prev_pop = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        prev_pop = 1'b0;
      end else begin
        if (prev_v && !prev_pop) begin
          chk("out_valid_held", bus.out_valid, 1);
          chk("out_data_stable", bus.out_data, prev_d);
        end
        if (bus.start) n_start++;
        if (bus.out_valid && bus.out_ready) begin
          rx_q.push_back(bus.out_data);
          last_pop_cyc = cyc;
        end
        prev_v   = bus.out_valid;
        prev_pop = bus.out_valid && bus.out_ready;
        prev_d   = bus.out_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int st;
    int stalls_tot;
    int idx;
    int k;
    logic acc;

    vecs[0] = '{2'b01, 3'd2, 2, {32'h0, 32'h0, 32'h22222222, 32'h11111111},
                1, {64'h0, 64'h22222222_11111111}, 16'd1};
    vecs[1] = '{2'b00, 3'd3, 3, {32'h0, 32'h0000000C, 32'h0000000B, 32'h0000000A},
                2, {64'h00000000_0000000C, 64'h0000000B_0000000A}, 16'd2};
    vecs[2] = '{2'b11, 3'd5, 1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                1, {64'h0, 64'h00000000_DEADBEEF}, 16'd1};
    vecs[3] = '{2'b10, 3'd1, 4, {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001},
                2, {64'h00000004_00000003, 64'h00000002_00000001}, 16'd2};

    bus.cmd_valid   = 1'b0;
    bus.cmd_mode    = '0;
    bus.cmd_sec_lvl = '0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.s_last      = 1'b0;
    bus.out_ready   = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_reset_vals();
    rst = 1'b0;
    #1;
    chk("cmd_ready_after_rst", bus.cmd_ready, 1);

    // Table-driven messages with the core always ready
    for (int v = 0; v < 4; v++) begin
      rx_q.delete();
      n_start = 0;
      bus.out_ready = 1'b1;
      send_cmd(vecs[v].mode, vecs[v].sec);
      chk("start_T1", bus.start, 1);
      chk("mode_T1", bus.mode, vecs[v].mode);
      chk("sec_lvl_T1", bus.sec_lvl, vecs[v].sec);
      chk("busy_T1", bus.busy, 1);
      chk("s_ready_T1", bus.s_ready, 0);
      tick();
      chk("start_T2", bus.start, 0);
      chk("s_ready_T2", bus.s_ready, 1);
      stalls_tot = 0;
      for (int i = 0; i < vecs[v].nw; i++) begin
        send_word(vecs[v].w[i], (i == vecs[v].nw - 1), st);
        stalls_tot += st;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      chk("no_stall", stalls_tot, 0);
      wait_idle();
      chk("idle_latency", cyc, last_pop_cyc + 1);
      chk("beat_cnt", bus.beat_cnt, vecs[v].cnt);
      chk("beat_count_rx", rx_q.size(), vecs[v].nb);
      for (int j = 0; j < vecs[v].nb; j++) begin
        if (j < rx_q.size()) chk("beat_data", rx_q[j], vecs[v].b[j]);
      end
      chk("single_start", n_start, 1);
      chk("mode_held", bus.mode, vecs[v].mode);
      chk("sec_lvl_held", bus.sec_lvl, vecs[v].sec);
      chk("busy_idle", bus.busy, 0);
    end

    // Back-pressure: 8 words with the core stalled, then released
    rx_q.delete();
    bus.out_ready = 1'b0;
    send_cmd(2'b00, 3'd0);
    tick();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h100 + 32'(idx);
      bus.s_last  = (idx == 7);
      acc = bus.s_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp_words_accepted", idx, 4);
    chk("bp_s_ready_low", bus.s_ready, 0);
    chk("bp_beats_held", rx_q.size(), 0);
    bus.out_ready = 1'b1;
    k = 0;
    while (idx < 8 && k < 60) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h100 + 32'(idx);
      bus.s_last  = (idx == 7);
      acc = bus.s_ready;
      tick();
      if (acc) idx++;
      k++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("bp_all_words", idx, 8);
    wait_idle();
    chk("bp_beats_rx", rx_q.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < rx_q.size())
        chk("bp_beat", rx_q[j], {32'h101 + 32'(2 * j), 32'h100 + 32'(2 * j)});
    end
    chk("bp_beat_cnt", bus.beat_cnt, 4);

    // Command held high while busy must not retrigger until drained
    rx_q.delete();
    n_start = 0;
    bus.out_ready   = 1'b0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_mode    = 2'b10;
    bus.cmd_sec_lvl = 3'd4;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin
      tick();
      k++;
    end
    tick();
    bus.cmd_mode    = 2'b11;
    bus.cmd_sec_lvl = 3'd6;
    tick();
    send_word(32'hAAAA0001, 1'b0, st);
    bus.s_valid = 1'b0;
    repeat (3) tick();
    chk("hold_fillhi_busy", bus.busy, 1);
    chk("hold_fillhi_cmd_ready", bus.cmd_ready, 0);
    chk("hold_fillhi_mode", bus.mode, 2'b10);
    chk("hold_fillhi_sec", bus.sec_lvl, 3'd4);
    send_word(32'hAAAA0002, 1'b1, st);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (4) tick();
    chk("hold_drain_cmd_ready", bus.cmd_ready, 0);
    chk("hold_drain_starts", n_start, 1);
    chk("hold_drain_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    k = 0;
    while (!bus.start && k < 20) begin
      tick();
      k++;
    end
    chk("hold_second_start", bus.start, 1);
    chk("hold_drained_first", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("hold_beat", rx_q[0], 64'hAAAA0002_AAAA0001);
    chk("hold_new_mode", bus.mode, 2'b11);
    chk("hold_new_sec", bus.sec_lvl, 3'd6);
    bus.cmd_valid = 1'b0;
    tick();
    send_word(32'h5A5A5A5A, 1'b1, st);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    wait_idle();
    chk("hold_rx_total", rx_q.size(), 2);
    if (rx_q.size() > 1) chk("hold_tail_beat", rx_q[1], 64'h00000000_5A5A5A5A);
    chk("hold_total_starts", n_start, 2);

    // Reset in the middle of a message
    rx_q.delete();
    bus.out_ready = 1'b0;
    send_cmd(2'b01, 3'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      send_word(32'hC0 + 32'(i), 1'b0, st);
    end
    bus.s_valid = 1'b0;
    chk("mid_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    tick();
    check_reset_vals();
    rst = 1'b0;
    #1;
    chk("mid_cmd_ready", bus.cmd_ready, 1);
    bus.out_ready = 1'b1;
    n_start = 0;
    send_cmd(2'b10, 3'd3);
    tick();
    send_word(32'h55555555, 1'b0, st);
    send_word(32'h66666666, 1'b1, st);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    wait_idle();
    chk("post_rst_rx", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("post_rst_beat", rx_q[0], 64'h66666666_55555555);
    chk("post_rst_beat_cnt", bus.beat_cnt, 1);
    chk("post_rst_starts", n_start, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
